// File: rtl/bpsk_demodulator.sv
// Coherent integrate-and-dump BPSK receiver: correlates samples against a
// +/-1 square-wave reference and dumps a sign decision once per bit.
module bpsk_demodulator #(
  parameter int DATA_W              = 8,
  parameter int SAMPLES_PER_CARRIER = 50,
  parameter int SAMPLES_PER_BIT     = 3750,
  parameter int ACC_W               = 21,
  parameter int LOCK_THRESH         = 100000,
  parameter int LOCK_COUNT          = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] sample_in,
  input  logic                     sample_valid,
  input  logic                     sync,
  output logic                     bit_out,
  output logic                     bit_valid,
  output logic signed [ACC_W-1:0]  corr_out,
  output logic                     locked
);

  localparam int CW = (SAMPLES_PER_CARRIER > 1) ?
                      $clog2(SAMPLES_PER_CARRIER) : 1;
  localparam int BW = (SAMPLES_PER_BIT > 1) ?
                      $clog2(SAMPLES_PER_BIT) : 1;
  localparam int GW = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SYNC,
    INTEGRATE
  } state_t;

  state_t                   state_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  corr_q;
  logic [CW-1:0]            ccnt_q;
  logic [BW-1:0]            bcnt_q;
  logic [GW-1:0]            good_q;
  logic                     locked_q;
  logic                     bit_out_q;
  logic                     bit_valid_q;

  logic signed [ACC_W-1:0]  ext_d;
  logic signed [ACC_W-1:0]  term_d;
  logic signed [ACC_W-1:0]  sum_d;
  logic [ACC_W-1:0]         mag_d;
  logic [CW-1:0]            ccnt_d;
  logic [GW-1:0]            good_d;
  logic                     last_d;
  logic                     good_bit_d;

  // Extend before negating so that -(-128) becomes +128, not -128.
  always_comb begin
    ext_d      = {{(ACC_W-DATA_W){sample_in[DATA_W-1]}}, sample_in};
    term_d     = (ccnt_q < CW'(SAMPLES_PER_CARRIER/2)) ? ext_d : -ext_d;
    sum_d      = acc_q + term_d;
    mag_d      = sum_d[ACC_W-1] ? -sum_d : sum_d;
    good_bit_d = (mag_d >= ACC_W'(LOCK_THRESH));
    ccnt_d     = (ccnt_q == CW'(SAMPLES_PER_CARRIER-1)) ?
                 '0 : ccnt_q + CW'(1);
    good_d     = (good_q == GW'(LOCK_COUNT)) ?
                 good_q : good_q + GW'(1);
    last_d     = (bcnt_q == BW'(SAMPLES_PER_BIT-1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      corr_q      <= '0;
      ccnt_q      <= '0;
      bcnt_q      <= '0;
      good_q      <= '0;
      locked_q    <= 1'b0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
    end else begin
      bit_valid_q <= 1'b0;
      if (!enable) begin
        state_q  <= IDLE;
        acc_q    <= '0;
        ccnt_q   <= '0;
        bcnt_q   <= '0;
        good_q   <= '0;
        locked_q <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: state_q <= WAIT_SYNC;
          WAIT_SYNC: begin
            if (sync && sample_valid) begin
              acc_q   <= ext_d;
              ccnt_q  <= CW'(1);
              bcnt_q  <= BW'(1);
              state_q <= INTEGRATE;
            end
          end
          INTEGRATE: begin
            if (sample_valid && sync) begin
              acc_q    <= ext_d;
              ccnt_q   <= CW'(1);
              bcnt_q   <= BW'(1);
              good_q   <= '0;
              locked_q <= 1'b0;
            end else if (sample_valid) begin
              ccnt_q <= ccnt_d;
              if (last_d) begin
                acc_q       <= '0;
                bcnt_q      <= '0;
                corr_q      <= sum_d;
                bit_out_q   <= !sum_d[ACC_W-1] && (sum_d != '0);
                bit_valid_q <= 1'b1;
                if (good_bit_d) begin
                  good_q   <= good_d;
                  locked_q <= (good_d == GW'(LOCK_COUNT));
                end else begin
                  good_q   <= '0;
                  locked_q <= 1'b0;
                end
              end else begin
                acc_q  <= sum_d;
                bcnt_q <= bcnt_q + BW'(1);
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign corr_out  = corr_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_bpsk_demodulator.sv
// Scoreboard bench for bpsk_demodulator: directed bits push expected dumps,
// a monitor pops and compares on every bit_valid strobe.
module tb_bpsk_demodulator;

  localparam int DW  = 8;
  localparam int SPC = 4;
  localparam int SPB = 8;
  localparam int AW  = 12;

  typedef struct {
    logic                 b;
    logic signed [AW-1:0] c;
    logic                 l;
    int                   t;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 enable = 1'b0;
  logic signed [DW-1:0] sample_in = '0;
  logic                 sample_valid = 1'b0;
  logic                 sync = 1'b0;
  logic                 bit_out;
  logic                 bit_valid;
  logic signed [AW-1:0] corr_out;
  logic                 locked;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t q[$];

  bpsk_demodulator #(
    .DATA_W(DW),
    .SAMPLES_PER_CARRIER(SPC),
    .SAMPLES_PER_BIT(SPB),
    .ACC_W(AW),
    .LOCK_THRESH(400),
    .LOCK_COUNT(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .sample_in(sample_in),
    .sample_valid(sample_valid),
    .sync(sync),
    .bit_out(bit_out),
    .bit_valid(bit_valid),
    .corr_out(corr_out),
    .locked(locked)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (bit_valid === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_bit_valid cyc=%0d bit=%0b corr=%0d",
                 cyc, bit_out, corr_out);
      end else begin
        e = q.pop_front();
        if (bit_out !== e.b || corr_out !== e.c ||
            locked !== e.l || cyc != e.t) begin
          errors++;
          $display("FAIL dump got bit=%0b corr=%0d lock=%0b cyc=%0d %s",
                   bit_out, corr_out, locked, cyc, "");
          $display("  required bit=%0b corr=%0d lock=%0b cyc=%0d",
                   e.b, e.c, e.l, e.t);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic drive(input int s, input logic v, input logic sy);
    @(negedge clk);
    sample_in    = 8'(s);
    sample_valid = v;
    sync         = sy;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 1'b0, 1'b0);
  endtask

  task automatic seq(input int a, input int b, input int c, input int d,
                     input logic sy, input logic gap,
                     input int first, input int last, input logic push,
                     input logic eb, input int ec, input logic el);
    int   pat[4];
    exp_t e;
    pat = '{a, b, c, d};
    for (int i = first; i <= last; i++) begin
      drive(pat[i%4], 1'b1, sy && (i == first));
      if (push && i == SPB-1) begin
        e.b = eb;
        e.c = AW'(ec);
        e.l = el;
        e.t = cyc + 1;
        q.push_back(e);
      end
      if (gap) drive(0, 1'b0, 1'b0);
    end
  endtask

  task automatic bitx(input int a, input int b, input int c, input int d,
                      input logic sy, input logic gap,
                      input logic eb, input int ec, input logic el);
    seq(a, b, c, d, sy, gap, 0, SPB-1, 1'b1, eb, ec, el);
  endtask

  task automatic part(input int a, input int b, input int c, input int d,
                      input logic sy, input int first, input int last);
    seq(a, b, c, d, sy, 1'b0, first, last, 1'b0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_bit_out", bit_out, 0);
    chk("reset_bit_valid", bit_valid, 0);
    chk("reset_corr", corr_out, 0);
    chk("reset_locked", locked, 0);
    rst = 1'b0;
    idle(1);
    enable = 1'b1;
    idle(1);

    bitx(100, 100, -100, -100, 1, 0, 1, 800, 0);
    bitx(-100, -100, 100, 100, 0, 0, 0, -800, 0);
    bitx(-128, -128, 127, 127, 0, 0, 0, -1020, 1);
    bitx(100, 100, -100, -100, 0, 1, 1, 800, 1);
    bitx(0, 0, 0, 0, 0, 0, 0, 0, 0);

    bitx(100, 100, -100, -100, 0, 0, 1, 800, 0);
    bitx(100, 100, -100, -100, 0, 0, 1, 800, 0);
    bitx(-100, -100, 100, 100, 0, 0, 0, -800, 1);
    bitx(50, 50, -50, -50, 0, 0, 1, 400, 1);
    bitx(40, 40, -40, -40, 0, 0, 1, 320, 0);

    bitx(100, 100, -100, -100, 0, 0, 1, 800, 0);
    bitx(100, 100, -100, -100, 0, 0, 1, 800, 0);
    bitx(100, 100, -100, -100, 0, 0, 1, 800, 1);
    part(100, 100, -100, -100, 0, 0, 4);
    drive(100, 1'b1, 1'b1);
    fork
      begin
        @(posedge clk);
        #2;
        chk("realign_locked", locked, 0);
      end
    join_none
    seq(100, 100, -100, -100, 0, 0, 1, SPB-1, 1, 1, 800, 0);
    bitx(-100, -100, 100, 100, 0, 0, 0, -800, 0);
    bitx(100, 100, -100, -100, 0, 0, 1, 800, 1);

    part(-100, -100, 100, 100, 0, 0, 4);
    @(negedge clk);
    enable       = 1'b0;
    sample_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("abort_bit_valid", bit_valid, 0);
    chk("abort_bit_out_hold", bit_out, 1);
    chk("abort_corr_hold", corr_out, 800);
    chk("abort_locked", locked, 0);
    @(negedge clk);
    enable = 1'b1;
    idle(1);
    bitx(-100, -100, 100, 100, 1, 0, 0, -800, 0);

    part(100, 100, -100, -100, 0, 0, 2);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_bit_out", bit_out, 0);
    chk("rst_corr", corr_out, 0);
    chk("rst_locked", locked, 0);
    chk("rst_bit_valid", bit_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    part(100, 100, 100, 100, 0, 0, 2);
    bitx(100, 100, -100, -100, 1, 0, 1, 800, 0);

    idle(5);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
